// File: rtl/dmem_port_arbiter.sv
// Two-requester round-robin sequencer in front of the byte-addressed data memory.
// Define DMEM_ARB_TRAP_EN to reject misaligned or out-of-range accesses with rN_err.
module dmem_port_arbiter #(
  parameter int unsigned MEM_BYTES  = 4096,
  parameter int unsigned FIRST_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  // requester 0: CPU load/store unit
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [1:0]  r0_len,
  input  logic        r0_sign,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ack,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  // requester 1: loader/debug/DMA port
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [1:0]  r1_len,
  input  logic        r1_sign,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ack,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  // DMem side
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_len,
  output logic        mem_sign,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] LenByte  = 2'b00;
  localparam logic [1:0] LenHalf  = 2'b01;
  localparam logic [1:0] LenWord  = 2'b10;
  localparam logic       LastInit = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

  if (MEM_BYTES < 4 || FIRST_PRIO > 1) begin : g_bad_params
    $error("dmem_port_arbiter: MEM_BYTES must be >= 4 and FIRST_PRIO must be 0 or 1");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StDone} state_e;

  state_e state_q;
  logic   win_q;
  logic   last_q;
  logic   we_q;
  logic   trap_q;

  logic        gnt;
  logic        sel_we;
  logic        sel_sign;
  logic        sel_trap;
  logic [1:0]  sel_len;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  // Winner is the requester not granted last time when both are asking.
  always_comb begin
    gnt = r1_req;
    if (r0_req && r1_req) begin
      gnt = ~last_q;
    end
    sel_we    = gnt ? r1_we    : r0_we;
    sel_sign  = gnt ? r1_sign  : r0_sign;
    sel_addr  = gnt ? r1_addr  : r0_addr;
    sel_wdata = gnt ? r1_wdata : r0_wdata;
    sel_len   = gnt ? r1_len   : r0_len;
    if (sel_len == 2'b11) begin
      sel_len = LenWord;
    end
  end

`ifdef DMEM_ARB_TRAP_EN
  logic [32:0] sel_end;
  logic        sel_misal;

  always_comb begin
    sel_end   = {1'b0, sel_addr} + ((sel_len == LenByte) ? 33'd1 :
                                    (sel_len == LenHalf) ? 33'd2 : 33'd4);
    sel_misal = ((sel_len == LenHalf) && sel_addr[0]) ||
                ((sel_len == LenWord) && (sel_addr[1:0] != 2'b00));
    sel_trap  = sel_misal || (sel_end > 33'(MEM_BYTES));
  end

  // err rides alongside the ack raised when a rejected access leaves ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r0_err <= 1'b0;
      r1_err <= 1'b0;
    end else begin
      r0_err <= (state_q == StIssue) && trap_q && !win_q;
      r1_err <= (state_q == StIssue) && trap_q &&  win_q;
    end
  end
`else
  assign sel_trap = 1'b0;
  assign r0_err   = 1'b0;
  assign r1_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      win_q     <= 1'b0;
      last_q    <= LastInit;
      we_q      <= 1'b0;
      trap_q    <= 1'b0;
      busy      <= 1'b0;
      r0_ack    <= 1'b0;
      r1_ack    <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_len   <= LenByte;
      mem_sign  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      r0_ack    <= 1'b0;
      r1_ack    <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (r0_req || r1_req) begin
            win_q     <= gnt;
            we_q      <= sel_we;
            trap_q    <= sel_trap;
            mem_len   <= sel_len;
            mem_sign  <= sel_sign;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            // Strobes are high only during the ISSUE cycle that follows.
            mem_read  <= !sel_we && !sel_trap;
            mem_write <=  sel_we && !sel_trap;
            busy      <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          if (we_q || trap_q) begin
            r0_ack  <= !win_q;
            r1_ack  <=  win_q;
            state_q <= StDone;
          end else begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          if (win_q) begin
            r1_rdata <= mem_rdata;
          end else begin
            r0_rdata <= mem_rdata;
          end
          r0_ack  <= !win_q;
          r1_ack  <=  win_q;
          state_q <= StDone;
        end
        StDone: begin
          last_q  <= win_q;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
